divider_seq: RTL and testbench
==============================

# divider_seq

Sequential restoring integer divider: the inverse datapath of the systolic-array multiplier. Takes an IA_W-bit dividend (the multiplier's product width) and an IB_W-bit divisor, and returns quotient and remainder after a fixed, data-independent latency. Used for requantization and rescaling of accumulated products. Ready/valid handshakes on both sides; one division in flight.

## Interface
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands.
- IA_W, 32: dividend and quotient width.
- IB_W, 16: divisor and remainder width; IB_W ≤ IA_W.
- BITS_PER_CYCLE, 1: quotient bits resolved per cycle; must divide IA_W. N = IA_W/BITS_PER_CYCLE.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_en_ff  in  1  global stall; low freezes every state register.
- i_valid  in  1  operands valid.
- o_ready  out  1  divider can accept operands.
- i_dividend  in  IA_W  dividend.
- i_divisor  in  IB_W  divisor.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_quot  out  IA_W  quotient.
- o_rem  out  IB_W  remainder.
- o_div_zero  out  1  divisor was zero.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state IDLE.
- o_ready = (state == IDLE) && i_en_ff. Accept when i_valid && o_ready: latch |dividend|, |divisor|, sign flags, and the zero flag; clear the step counter; go to CALC.
- CALC: each enabled cycle performs BITS_PER_CYCLE restoring steps (shift partial remainder left, trial-subtract the divisor, set the quotient bit if the result is non-negative). The counter increments per cycle. On the Nth step go to DONE.
- DONE: o_valid = 1. Outputs come from registers and stay stable while i_ready is low. When o_valid && i_ready && i_en_ff, go to IDLE.
- Signed correction, applied when entering DONE: quotient negated if the operand signs differ (truncation toward zero). Remainder takes the dividend's sign.
- Divide by zero: fixed latency still applies. o_quot = all ones, o_rem = i_dividend[IB_W-1:0], o_div_zero = 1.
- Signed overflow (most-negative dividend / −1): o_quot = most-negative value, o_rem = 0. No flag.
- The internal partial remainder is IB_W+1 bits. The unsigned remainder always fits in IB_W bits.
- i_en_ff low: state, counter, and datapath are held. o_ready is forced low and the output handshake does not complete. o_valid holds its value.
- i_rst asserted in any state, including mid-CALC: the FSM returns to IDLE immediately and the in-flight division is discarded.

## Timing
- Reset values: o_valid = 0, o_quot = 0, o_rem = 0, o_div_zero = 0. o_ready = 1 whenever i_en_ff is high.
- Accept in cycle 0 gives o_valid first high in cycle N+1, assuming i_en_ff stays high. Each stalled cycle adds one cycle.
- Earliest next accept is the cycle after the output handshake. Maximum throughput is one result per N+2 cycles.
- o_ready is low from the accept edge until the FSM returns to IDLE. No combinational path runs from i_valid to o_ready or from i_ready to o_valid.

## Structure
- Package sauria_div_pkg:
  - state enum typedef (IDLE, CALC, DONE);
  - counter-width localparam function $clog2(N+1);
  - the divide-by-zero result encoding.
- Sub-module div_step: one combinational restoring iteration (partial remainder in, quotient bit and next partial remainder out). Instantiated BITS_PER_CYCLE times in a chain.
- Top level holds the FSM, counter, operand registers, and sign correction.

## Test plan
All scenarios use IA_W = 32, IB_W = 16, BITS_PER_CYCLE = 1 unless stated.
- Unsigned 1000 / 7, accept in cycle 0 -> o_valid in cycle 33; o_quot = 142, o_rem = 6, o_div_zero = 0.
- SIGNED = 1, −1000 / 7 -> o_quot = 0xFFFFFF72, o_rem = 0xFFFA. 1000 / −7 -> o_quot = 0xFFFFFF72, o_rem = 6.
- 0x12345678 / 0 -> o_quot = 0xFFFFFFFF, o_rem = 0x5678, o_div_zero = 1, latency still 33. SIGNED = 1, 0x80000000 / 0xFFFF -> o_quot = 0x80000000, o_rem = 0.
- i_ready held low for 5 cycles after o_valid -> outputs stable and o_ready low; the next accept is possible in the cycle after the handshake.
- i_en_ff low for 4 cycles during CALC -> o_valid in cycle 37 with a correct result. i_rst pulse in cycle 10 of CALC -> o_valid = 0 and o_ready = 1 after release; a new 1000 / 7 gives the correct result.
- BITS_PER_CYCLE = 4, 0xFFFFFFFF / 0xFFFF -> o_valid in cycle 9; o_quot = 0x00010001, o_rem = 0.

Source files
------------

// File: rtl/sauria_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package sauria_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Wide enough to count 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // A divide by zero reports this bit replicated across the whole quotient.
    localparam logic DIV_ZERO_QUOT_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring iteration: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
    parameter int IB_W = 16
) (
    input  logic [IB_W:0]   rem_in,
    input  logic            bit_in,
    input  logic [IB_W-1:0] divisor,
    output logic            q_bit,
    output logic [IB_W:0]   rem_out
);

    logic [IB_W+1:0] shifted;
    logic [IB_W+1:0] diff;

    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {2'b00, divisor};
    // A borrow lands in the top bit; no borrow means the subtraction is kept.
    assign q_bit   = ~diff[IB_W+1];
    assign rem_out = q_bit ? diff[IB_W:0] : shifted[IB_W:0];

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider with fixed latency, ready/valid on both sides, one division in flight.
module divider_seq
    import sauria_div_pkg::*;
#(
    parameter bit SIGNED         = 1'b0,
    parameter int IA_W           = 32,
    parameter int IB_W           = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en_ff,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [IA_W-1:0] i_dividend,
    input  logic [IB_W-1:0] i_divisor,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [IA_W-1:0] o_quot,
    output logic [IB_W-1:0] o_rem,
    output logic            o_div_zero,
    output logic [1:0]      o_state
);

    localparam int N     = IA_W / BITS_PER_CYCLE;
    localparam int CNT_W = cnt_width(N);

    div_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [IA_W-1:0] dvd_q;
    logic [IB_W-1:0] dvs_q;
    logic [IB_W:0]   rem_q;
    logic [IB_W-1:0] dvd_lo_q;
    logic            neg_quot_q, neg_rem_q, zero_q;
    logic [IA_W-1:0] quot_q;
    logic [IB_W-1:0] rem_o_q;
    logic            dz_q;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // o_ready depends only on state and i_en_ff, o_valid only on state.
    logic accept, last_step, deliver;
    assign o_ready   = (state_q == IDLE) && i_en_ff;
    assign o_valid   = (state_q == DONE);
    assign accept    = i_valid && o_ready;
    assign last_step = (state_q == CALC) && (cnt_q == CNT_W'(N - 1));
    assign deliver   = o_valid && i_ready && i_en_ff;
    assign o_state   = state_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (i_en_ff && last_step) state_d = DONE;
            DONE:    if (deliver) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand magnitudes; the most-negative value maps to itself, which is correct unsigned.
    logic dvd_neg, dvs_neg;
    logic [IA_W-1:0] dvd_mag;
    logic [IB_W-1:0] dvs_mag;
    assign dvd_neg = SIGNED && i_dividend[IA_W-1];
    assign dvs_neg = SIGNED && i_divisor[IB_W-1];
    assign dvd_mag = dvd_neg ? -i_dividend : i_dividend;
    assign dvs_mag = dvs_neg ? -i_divisor : i_divisor;

    logic [IB_W:0]           rem_chain [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] q_bits;
    assign rem_chain[0] = rem_q;

    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        div_step #(.IB_W(IB_W)) u_step (
            .rem_in  (rem_chain[k]),
            .bit_in  (dvd_q[IA_W-1-k]),
            .divisor (dvs_q),
            .q_bit   (q_bits[BITS_PER_CYCLE-1-k]),
            .rem_out (rem_chain[k+1])
        );
    end

    // The dividend register doubles as the quotient register: quotient bits shift in at the bottom.
    logic [IA_W-1:0] quot_next;
    logic [IB_W-1:0] rem_mag;
    logic [IA_W-1:0] res_quot;
    logic [IB_W-1:0] res_rem;
    assign quot_next = (dvd_q << BITS_PER_CYCLE) | IA_W'(q_bits);
    assign rem_mag   = rem_chain[BITS_PER_CYCLE][IB_W-1:0];
    assign res_quot  = zero_q ? {IA_W{DIV_ZERO_QUOT_BIT}}
                              : (neg_quot_q ? -quot_next : quot_next);
    assign res_rem   = zero_q ? dvd_lo_q : (neg_rem_q ? -rem_mag : rem_mag);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            dvd_lo_q   <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
            quot_q     <= '0;
            rem_o_q    <= '0;
            dz_q       <= 1'b0;
        end else if (i_en_ff) begin
            if (accept) begin
                cnt_q      <= '0;
                dvd_q      <= dvd_mag;
                dvs_q      <= dvs_mag;
                rem_q      <= '0;
                dvd_lo_q   <= i_dividend[IB_W-1:0];
                neg_quot_q <= dvd_neg ^ dvs_neg;
                neg_rem_q  <= dvd_neg;
                zero_q     <= (i_divisor == '0);
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q + 1'b1;
                dvd_q <= quot_next;
                rem_q <= rem_chain[BITS_PER_CYCLE];
                if (last_step) begin
                    quot_q  <= res_quot;
                    rem_o_q <= res_rem;
                    dz_q    <= zero_q;
                end
            end
        end
    end

    assign o_quot     = quot_q;
    assign o_rem      = rem_o_q;
    assign o_div_zero = dz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: unsigned, signed and 4-bits-per-cycle instances with a result scoreboard.
module tb_divider_seq;

    localparam int IA_W = 32;
    localparam int IB_W = 16;
    localparam int W    = IA_W + IB_W + 1;

    logic clk = 1'b0;
    logic rst, en_ff, rdy_in;
    logic            valid  [3];
    logic [IA_W-1:0] dvd    [3];
    logic [IB_W-1:0] dvs    [3];
    logic            ready  [3];
    logic            ovalid [3];
    logic            dz     [3];
    logic [IA_W-1:0] quot   [3];
    logic [IB_W-1:0] rem    [3];
    logic [1:0]      st     [3];

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    divider_seq #(.SIGNED(1'b0), .IA_W(IA_W), .IB_W(IB_W), .BITS_PER_CYCLE(1)) u_dut_u (
        .i_clk(clk), .i_rst(rst), .i_en_ff(en_ff), .i_valid(valid[0]), .o_ready(ready[0]),
        .i_dividend(dvd[0]), .i_divisor(dvs[0]), .o_valid(ovalid[0]), .i_ready(rdy_in),
        .o_quot(quot[0]), .o_rem(rem[0]), .o_div_zero(dz[0]), .o_state(st[0])
    );

    divider_seq #(.SIGNED(1'b1), .IA_W(IA_W), .IB_W(IB_W), .BITS_PER_CYCLE(1)) u_dut_s (
        .i_clk(clk), .i_rst(rst), .i_en_ff(en_ff), .i_valid(valid[1]), .o_ready(ready[1]),
        .i_dividend(dvd[1]), .i_divisor(dvs[1]), .o_valid(ovalid[1]), .i_ready(rdy_in),
        .o_quot(quot[1]), .o_rem(rem[1]), .o_div_zero(dz[1]), .o_state(st[1])
    );

    divider_seq #(.SIGNED(1'b0), .IA_W(IA_W), .IB_W(IB_W), .BITS_PER_CYCLE(4)) u_dut_b4 (
        .i_clk(clk), .i_rst(rst), .i_en_ff(en_ff), .i_valid(valid[2]), .o_ready(ready[2]),
        .i_dividend(dvd[2]), .i_divisor(dvs[2]), .o_valid(ovalid[2]), .i_ready(rdy_in),
        .o_quot(quot[2]), .o_rem(rem[2]), .o_div_zero(dz[2]), .o_state(st[2])
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Reference result {div_zero, quotient, remainder} from native integer arithmetic.
    function automatic logic [W-1:0] model(input bit sgn, input logic [IA_W-1:0] a,
                                           input logic [IB_W-1:0] b);
        longint sa, sb, q, r;
        if (b == '0) return {1'b1, 32'hFFFF_FFFF, a[IB_W-1:0]};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, q[IA_W-1:0], r[IB_W-1:0]};
    endfunction

    task automatic run_div(input int d, input logic [IA_W-1:0] a, input logic [IB_W-1:0] b,
                           input logic [W-1:0] exp, input int exp_lat,
                           input int stall_at, input int hold);
        int cyc;
        logic [W-1:0] e;
        @(negedge clk);
        valid[d] = 1'b1;
        dvd[d]   = a;
        dvs[d]   = b;
        rdy_in   = (hold == 0);
        check("ready_before_accept", ready[d], 1);
        exp_q.push_back(exp);
        @(posedge clk);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            valid[d] = 1'b0;
            if (cyc == stall_at)     en_ff = 1'b0;
            if (cyc == stall_at + 4) en_ff = 1'b1;
            if (cyc == 1) check("ready_low_busy", ready[d], 0);
            if (ovalid[d]) break;
            if (cyc >= 200) begin
                check("valid_timeout", ovalid[d], 1);
                void'(exp_q.pop_front());
                en_ff  = 1'b1;
                rdy_in = 1'b1;
                return;
            end
        end
        check("latency", cyc, exp_lat);
        e = exp_q.pop_front();
        check("quot", quot[d], e[W-2:IB_W]);
        check("rem", rem[d], e[IB_W-1:0]);
        check("div_zero", dz[d], e[W-1]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stable", {ovalid[d], ready[d], dz[d], quot[d], rem[d]}, {1'b1, 1'b0, e});
        end
        rdy_in = 1'b1;
        @(negedge clk);
        check("ready_after_handshake", ready[d], 1);
        check("valid_after_handshake", ovalid[d], 0);
    endtask

    task automatic abort_by_reset();
        @(negedge clk);
        valid[0] = 1'b1;
        dvd[0]   = 32'd1000;
        dvs[0]   = 16'd7;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            valid[0] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_valid", ovalid[0], 0);
        check("abort_ready", ready[0], 1);
        check("abort_state", st[0], 0);
    endtask

    initial begin
        logic [IA_W-1:0] a;
        logic [IB_W-1:0] b;
        int d;
        rst    = 1'b1;
        en_ff  = 1'b1;
        rdy_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            dvd[i]   = '0;
            dvs[i]   = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_ready", ready[i], 1);
            check("reset_outputs", {ovalid[i], dz[i], quot[i], rem[i]}, '0);
            check("reset_state", st[i], 0);
        end

        run_div(0, 32'd1000, 16'd7, {1'b0, 32'd142, 16'd6}, 33, -1, 0);
        run_div(1, 32'hFFFF_FC18, 16'd7, {1'b0, 32'hFFFF_FF72, 16'hFFFA}, 33, -1, 0);
        run_div(1, 32'd1000, 16'hFFF9, {1'b0, 32'hFFFF_FF72, 16'd6}, 33, -1, 0);
        run_div(0, 32'h1234_5678, 16'd0, {1'b1, 32'hFFFF_FFFF, 16'h5678}, 33, -1, 0);
        run_div(1, 32'h8000_0000, 16'hFFFF, {1'b0, 32'h8000_0000, 16'd0}, 33, -1, 0);
        run_div(1, 32'hFFFF_FFFB, 16'd0, {1'b1, 32'hFFFF_FFFF, 16'hFFFB}, 33, -1, 0);
        run_div(0, 32'd1000, 16'd7, {1'b0, 32'd142, 16'd6}, 33, -1, 5);
        run_div(0, 32'd123456, 16'd321, model(1'b0, 32'd123456, 16'd321), 37, 5, 0);
        abort_by_reset();
        run_div(0, 32'd1000, 16'd7, {1'b0, 32'd142, 16'd6}, 33, -1, 0);
        run_div(2, 32'hFFFF_FFFF, 16'hFFFF, {1'b0, 32'h0001_0001, 16'd0}, 9, -1, 0);

        for (int i = 0; i < 12; i++) begin
            d = i % 3;
            a = $urandom;
            case (i % 4)
                0:       b = 16'($urandom_range(1, 20));
                3:       b = '0;
                default: b = 16'($urandom_range(1, 65535));
            endcase
            run_div(d, a, b, model(d == 1, a, b), (d == 2) ? 9 : 33, -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
